posit16_field_decoder: RTL

- Two-stage pipelined decoder that splits a posit<16,ES> word into sign, special flags, signed scale and left-aligned fraction.
- Sits directly downstream of the input register and wraps the team's 16-bit leading-zero counter. That counter measures the regime run.
- Feeds the posit arithmetic datapath through a valid/ready handshake.

---
 rtl/posit16_field_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/posit16_field_decoder.sv
// rtl/posit16_field_decoder.sv - two-stage posit<16,ES> field decoder wrapping a 16-bit leading-zero counter

module posit16_lzc (
    input  logic [15:0] value,
    output logic [4:0]  count,
    output logic        all_zero
);

    // Scanning upward lets the highest set bit win; an all-zero word reports 16.
    always_comb begin
        count = 5'd16;
        for (int i = 0; i < 16; i++) begin
            if (value[i]) begin
                count = 5'(15 - i);
            end
        end
    end

    assign all_zero = (value == 16'd0);

endmodule

module posit16_field_decoder #(
    parameter int ES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_posit,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic        out_zero,
    output logic        out_nar,
    output logic [7:0]  out_scale,
    output logic [12:0] out_frac
);

    if (ES < 0 || ES > 2) begin : g_es_check
        $error("posit16_field_decoder: ES must be in 0..2");
    end

    logic        s1_valid;
    logic        s1_sign;
    logic        s1_zero;
    logic        s1_nar;
    logic [14:0] s1_abs;

    logic        s2_load;
    logic [14:0] in_abs;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Only the low 15 bits of the magnitude carry information past the sign.
    assign in_abs = in_posit[15] ? (15'(~in_posit[14:0]) + 15'd1) : in_posit[14:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_nar   <= 1'b0;
            s1_abs   <= 15'd0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_posit[15];
                s1_zero <= (in_posit == 16'h0000);
                s1_nar  <= (in_posit == 16'h8000);
                s1_abs  <= in_abs;
            end
        end
    end

    logic        r0;
    logic [15:0] regime_vec;
    logic [4:0]  lzc_count;
    logic        lzc_zero;
    logic [1:0]  lzc_unused;
    logic [3:0]  m;
    logic [5:0]  k;
    logic [14:0] rem;
    logic [1:0]  e;
    logic [7:0]  scale;
    logic [12:0] frac;

    assign r0 = s1_abs[14];

    // The trailing sentinel bit bounds the run, so the count is always 1..15.
    assign regime_vec = r0 ? {~s1_abs, 1'b1} : {s1_abs, 1'b1};

    posit16_lzc u_lzc (
        .value    (regime_vec),
        .count    (lzc_count),
        .all_zero (lzc_zero)
    );

    assign lzc_unused = {lzc_zero, lzc_count[4]};
    assign m          = lzc_count[3:0];
    assign k          = r0 ? ({2'b00, m} - 6'd1) : (6'd0 - {2'b00, m});
    assign rem        = s1_abs << ({1'b0, m} + 5'd1);
    assign e          = 2'(rem >> (15 - ES));
    assign frac       = 13'(rem >> (2 - ES));
    assign scale      = ({{2{k[5]}}, k} << ES) + {6'd0, e};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_nar   <= 1'b0;
            out_scale <= 8'd0;
            out_frac  <= 13'd0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_sign  <= s1_sign;
                out_zero  <= s1_zero;
                out_nar   <= s1_nar;
                out_scale <= (s1_zero || s1_nar) ? 8'd0 : scale;
                out_frac  <= (s1_zero || s1_nar) ? 13'd0 : frac;
            end
        end
    end

endmodule
